// File: rtl/zbt_req_ctrl.sv
// Request-side controller for a 36-bit pipelined ZBT/NoBL SRAM.
// One request per cycle feeds a fixed C1..C4 slot pipeline: address, write data, read capture, return.
module zbt_req_ctrl #(
  parameter int DSIZE       = 36,
  parameter int ASIZE       = 19,
  parameter int BWSIZE      = 4,
  parameter int INIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw_n,
  input  logic [ASIZE-1:0]  req_addr,
  input  logic [DSIZE-1:0]  req_wdata,
  input  logic [BWSIZE-1:0] req_bw,
  output logic              rd_valid,
  output logic [DSIZE-1:0]  rd_data,
  output logic              ctrl_idle,
  output logic [ASIZE-1:0]  sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_adv_ld_n,
  output logic [BWSIZE-1:0] sram_bw_n,
  output logic              sram_oe_n,
  output logic [DSIZE-1:0]  ctrl_in_rw_n,
  output logic [DSIZE-1:0]  data_in,
  input  logic [DSIZE-1:0]  read_data
);

  typedef enum logic {INIT, RUN} state_t;

  localparam int          STAGES    = 2;
  // INIT_CYCLES = 0 collapses to the same test as 1: leave INIT on the first edge.
  localparam logic [15:0] INIT_LAST = 16'((INIT_CYCLES == 0) ? 0 : INIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [15:0]       init_cnt;
  logic [STAGES:0]   vld_pipe;  // slot occupancy, bit 0 = C1 .. bit 2 = C3
  logic [STAGES:0]   rd_pipe;   // slot holds a read, same indexing
  logic [DSIZE-1:0]  wdata_q;
  logic              accept;
  logic              wr_c1;

  assign req_ready = (state == RUN);
  assign accept    = req_valid & req_ready;
  assign wr_c1     = vld_pipe[0] & ~rd_pipe[0];

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == INIT_LAST) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= INIT;
      init_cnt      <= '0;
      vld_pipe      <= '0;
      rd_pipe       <= '0;
      wdata_q       <= '0;
      ctrl_idle     <= 1'b0;
      sram_addr     <= '0;
      sram_ce_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_adv_ld_n <= 1'b1;
      sram_bw_n     <= '1;
      sram_oe_n     <= 1'b1;
      ctrl_in_rw_n  <= '1;
      data_in       <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 16'd1;

      vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
      rd_pipe   <= {rd_pipe[STAGES-1:0], accept & req_rw_n};
      // C3 moving to C4 still counts as in flight for one more cycle.
      ctrl_idle <= (state_nxt == RUN) && !accept && !(|vld_pipe);

      // C1: address/control stage
      if (accept) begin
        sram_addr     <= req_addr;
        sram_ce_n     <= 1'b0;
        sram_we_n     <= req_rw_n;
        sram_adv_ld_n <= 1'b0;
        sram_bw_n     <= req_rw_n ? '1 : ~req_bw;
        wdata_q       <= req_wdata;
      end else begin
        sram_ce_n     <= 1'b1;
        sram_we_n     <= 1'b1;
        sram_adv_ld_n <= (state_nxt != RUN);
        sram_bw_n     <= '1;
      end

      // C2: arm the I/O stage so it drives dq during C3, matching the SRAM write latency
      ctrl_in_rw_n <= wr_c1 ? '0 : '1;
      if (wr_c1) data_in <= wdata_q;

      // C3: SRAM drives dq for reads
      sram_oe_n <= ~(vld_pipe[1] & rd_pipe[1]);

      // C4: capture at the end of C3 and present
      rd_valid <= vld_pipe[2] & rd_pipe[2];
      if (vld_pipe[2] & rd_pipe[2]) rd_data <= read_data;
    end
  end

endmodule

// File: tb/tb_zbt_req_ctrl.sv
// Directed bench for zbt_req_ctrl: pin checks per slot, a small ZBT SRAM model with
// dq-ownership checks, and a read-return scoreboard drained by a separate monitor.
module tb_zbt_req_ctrl;
  localparam int DSIZE = 36, ASIZE = 19, BWSIZE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_rw_n;
  logic [ASIZE-1:0]  req_addr;
  logic [DSIZE-1:0]  req_wdata;
  logic [BWSIZE-1:0] req_bw;
  logic              rd_valid, ctrl_idle;
  logic [DSIZE-1:0]  rd_data;
  logic [ASIZE-1:0]  sram_addr;
  logic              sram_ce_n, sram_we_n, sram_adv_ld_n, sram_oe_n;
  logic [BWSIZE-1:0] sram_bw_n;
  logic [DSIZE-1:0]  ctrl_in_rw_n, data_in;
  logic [DSIZE-1:0]  read_data = '0;

  always #5 clk = ~clk;

  zbt_req_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .BWSIZE(BWSIZE), .INIT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw_n(req_rw_n),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bw(req_bw),
    .rd_valid(rd_valid), .rd_data(rd_data), .ctrl_idle(ctrl_idle),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .sram_adv_ld_n(sram_adv_ld_n), .sram_bw_n(sram_bw_n), .sram_oe_n(sram_oe_n),
    .ctrl_in_rw_n(ctrl_in_rw_n), .data_in(data_in), .read_data(read_data)
  );

  int checks = 0, errors = 0;
  logic [DSIZE-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // SRAM model: slot captured at end of C1 (sa), active on dq in C3 (sb).
  bit [DSIZE-1:0]   mem [int];
  logic             sa_v = 0, sa_we = 0, sb_v = 0, sb_we = 0, io_drv = 0;
  logic [ASIZE-1:0] sa_addr = '0, sb_addr = '0;
  logic [DSIZE-1:0] io_dat = '0;

  initial mem[32'h7FFFF] = 36'h5_5AA5_0F0F;

  always @(posedge clk) begin
    if (!reset) begin
      sa_v = 0; sb_v = 0; io_drv = 0;
    end else begin
      chk("dq_io_owner", io_drv, sb_v & sb_we);
      chk("dq_oe_owner", sram_oe_n, !(sb_v & !sb_we));
      if (sb_v && sb_we && io_drv) mem[int'(sb_addr)] = io_dat;
      if (sa_v && !sa_we)
        read_data <= mem.exists(int'(sa_addr)) ? mem[int'(sa_addr)] : '0;
      else
        read_data <= 36'hF_0BAD_0BAD;
      sb_v = sa_v; sb_we = sa_we; sb_addr = sa_addr;
      io_drv = (ctrl_in_rw_n == '0);
      io_dat = data_in;
      sa_v = !sram_ce_n; sa_we = !sram_we_n; sa_addr = sram_addr;
    end
  end

  // Read-return monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got rd_valid with data %0h, expected no read", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 0; req_valid = 0; req_rw_n = 1; req_addr = '0; req_wdata = '0; req_bw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_idle", ctrl_idle, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_ctl", {sram_ce_n, sram_we_n, sram_adv_ld_n, sram_oe_n}, 4'hF);
    chk("rst_bw_n", sram_bw_n, 4'hF);
    chk("rst_rw_n", ctrl_in_rw_n, 36'hF_FFFF_FFFF);
    chk("rst_data_in", data_in, 0);

    reset = 1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk("init_ready", req_ready, k >= 16);
      chk("init_idle", ctrl_idle, k >= 16);
      chk("init_ce_n", sram_ce_n, 1);
    end

    // single write
    req_valid = 1; req_rw_n = 0; req_addr = 19'h00012; req_wdata = 36'h9_ABCD_1234; req_bw = 4'b0101;
    tick(); req_valid = 0;
    chk("wr_c1_ce_we", {sram_ce_n, sram_we_n, sram_adv_ld_n}, 3'b000);
    chk("wr_c1_bw_n", sram_bw_n, 4'b1010);
    chk("wr_c1_addr", sram_addr, 19'h00012);
    tick();
    chk("wr_c2_rw_n", ctrl_in_rw_n, 0);
    chk("wr_c2_data", data_in, 36'h9_ABCD_1234);
    tick();
    chk("wr_c3_rw_n", ctrl_in_rw_n, 36'hF_FFFF_FFFF);
    chk("wr_c3_ce_n", sram_ce_n, 1);
    tick();

    // single read
    req_valid = 1; req_rw_n = 1; req_addr = 19'h00012;
    exp_q.push_back(36'h9_ABCD_1234);
    tick(); req_valid = 0;
    chk("rd_c1_ce_we", {sram_ce_n, sram_we_n}, 2'b01);
    chk("rd_c1_bw_n", sram_bw_n, 4'hF);
    chk("rd_c1_oe_n", sram_oe_n, 1);
    tick();
    chk("rd_c2_oe_n", sram_oe_n, 1);
    chk("rd_c2_rw_n", ctrl_in_rw_n, 36'hF_FFFF_FFFF);
    tick();
    chk("rd_c3_oe_n", sram_oe_n, 0);
    chk("rd_c3_valid", rd_valid, 0);
    tick();
    chk("rd_c4_oe_n", sram_oe_n, 1);
    chk("rd_c4_valid", rd_valid, 1);
    chk("rd_c4_idle", ctrl_idle, 0);
    tick();
    chk("rd_c5_valid", rd_valid, 0);
    chk("rd_c5_idle", ctrl_idle, 1);
    chk("rd_c5_hold", rd_data, 36'h9_ABCD_1234);

    // back-to-back W0 R0 W1 R1
    req_valid = 1; req_rw_n = 0; req_addr = 19'h0; req_wdata = 36'h1; req_bw = 4'hF;
    chk("b2b_ready0", req_ready, 1);
    tick(); req_rw_n = 1; exp_q.push_back(36'h1);
    chk("b2b_ready1", req_ready, 1);
    tick(); req_rw_n = 0; req_addr = 19'h1; req_wdata = 36'h2;
    chk("b2b_ready2", req_ready, 1);
    tick(); req_rw_n = 1; exp_q.push_back(36'h2);
    chk("b2b_ready3", req_ready, 1);
    tick(); req_valid = 0;
    repeat (6) tick();
    chk("b2b_drained", exp_q.size(), 0);

    // reset in C2 of a read; a read of 0x7FFFF is then held pending through INIT
    req_valid = 1; req_rw_n = 1; req_addr = 19'h0;
    tick(); req_valid = 0;
    tick();
    reset = 0; req_valid = 1; req_rw_n = 1; req_addr = 19'h7FFFF;
    tick();
    chk("mid_rst_rw_n", ctrl_in_rw_n, 36'hF_FFFF_FFFF);
    chk("mid_rst_ce_n", sram_ce_n, 1);
    chk("mid_rst_ready", req_ready, 0);
    reset = 1;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      tick(); n++;
      if (req_ready !== 1'b1) chk("reinit_ce_n", sram_ce_n, 1);
    end
    chk("reinit_edges", n, 16);
    exp_q.push_back(36'h5_5AA5_0F0F);
    tick(); req_valid = 0;
    chk("pend_addr", sram_addr, 19'h7FFFF);
    chk("pend_ce_we", {sram_ce_n, sram_we_n}, 2'b01);
    repeat (6) tick();
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
